uart_tx_arbiter: RTL

- Shares one UART byte transmitter among NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake.
- Sequences the transmitter's tx_start / tx_busy / tx_clear_req handshake, reports per-requester completion or timeout, and adds a configurable inter-frame gap.
- Sits between firmware-facing request sources (Wishbone CSR mailbox, debug printer) and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NUM_REQ requesters,
// sequencing the tx_start / tx_busy / tx_clear_req handshake with timeouts and an inter-frame gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 1024,
    parameter int FRAME_TIMEOUT = 65535,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_clear_req,
    output logic                      arb_busy,
    output logic [2:0]                cur_owner
);

    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int MAX_TO_A = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
    localparam int MAX_TO   = (MAX_TO_A > GAP_CYCLES) ? MAX_TO_A : GAP_CYCLES;
    localparam int TIMER_W  = (MAX_TO > 2) ? $clog2(MAX_TO) : 1;

    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] FRAME_LAST = TIMER_W'(FRAME_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic [PTR_W-1:0]   winner;
    logic               any_valid;
    logic               grant;
    logic [DATA_W-1:0]  win_data;

    // Scan downward in offset so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner) == i) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign grant     = (state == IDLE) && any_valid;
    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    assign arb_busy  = (state != IDLE);
    assign cur_owner = 3'(owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            req_done <= '0;
            req_err  <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        tx_data  <= win_data;
                        owner    <= winner;
                        rr_ptr   <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                        timer    <= '0;
                        tx_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // tx_clear_req is deliberately ignored until the transmitter has reported busy.
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        timer    <= '0;
                        state    <= WAIT_DONE;
                    end else if (timer == START_LAST) begin
                        tx_start       <= 1'b0;
                        req_err[owner] <= 1'b1;
                        timer          <= '0;
                        state          <= GAP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                WAIT_DONE: begin
                    if (tx_clear_req) begin
                        req_done[owner] <= 1'b1;
                        timer           <= '0;
                        state           <= GAP;
                    end else if (timer == FRAME_LAST) begin
                        req_err[owner] <= 1'b1;
                        timer          <= '0;
                        state          <= GAP;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
